// File: rtl/synaptic_accumulator_pkg.sv
// synaptic_accumulator_pkg: shared SNN types, default sizes and saturating arithmetic
//   state_t  : accumulator FSM states (ACCUM, DRAIN, EMIT)
//   sat_add  : signed add clamped to the range of a w-bit signed value
package synaptic_accumulator_pkg;

    typedef enum logic [1:0] {ACCUM, DRAIN, EMIT} state_t;

    localparam int N_SYN_DEFAULT = 16;
    localparam int ACC_W_DEFAULT = 24;
    localparam int WEIGHT_W      = 16;
    localparam int CURRENT_W     = 16;
    localparam int COUNT_W       = 8;

    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return s > hi ? hi : s < lo ? lo : s;
    endfunction

endpackage

// File: rtl/synapse_weight_rf.sv
// synapse_weight_rf: N_SYN x 16 weight register file, one write port, one registered read port
//   clk, reset : clock and synchronous active-high reset (clears only the read register)
//   we/waddr/wdata : weight write port
//   re/raddr   : read request; rdata holds the weight one cycle later, zero when no read
module synapse_weight_rf
    import synaptic_accumulator_pkg::*;
#(
    parameter  int N_SYN = N_SYN_DEFAULT,
    localparam int IW    = $clog2(N_SYN)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [IW-1:0]              waddr,
    input  logic signed [WEIGHT_W-1:0] wdata,
    input  logic                       re,
    input  logic [IW-1:0]              raddr,
    output logic signed [WEIGHT_W-1:0] rdata
);

    logic signed [WEIGHT_W-1:0] mem [N_SYN];

    // Weights survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Non-blocking read sees the pre-write value on a same-address collision.
    // A zero output when idle lets the consumer add unconditionally.
    always_ff @(posedge clk) begin
        rdata <= reset ? '0 : re ? mem[raddr] : '0;
    end

endmodule

// File: rtl/synaptic_accumulator.sv
// synaptic_accumulator: integrates weighted presynaptic spikes per timestep into a LIF input current
//   clk, reset                 : clock and synchronous active-high reset
//   spike_valid/idx/ready      : presynaptic event handshake, ready only while accumulating
//   w_we/w_addr/w_data         : weight write port, usable in any state
//   timestep_tick              : closes the integration window
//   input_current/current_valid: clamped window sum and its one-cycle update pulse
//   spike_count                : events accepted in the last closed window (saturates at 255)
//   overrun                    : sticky, a tick arrived while not accumulating
module synaptic_accumulator
    import synaptic_accumulator_pkg::*;
#(
    parameter  int N_SYN = N_SYN_DEFAULT,
    parameter  int ACC_W = ACC_W_DEFAULT,
    localparam int IW    = $clog2(N_SYN)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       spike_valid,
    input  logic [IW-1:0]              spike_idx,
    output logic                       spike_ready,
    input  logic                       w_we,
    input  logic [IW-1:0]              w_addr,
    input  logic signed [WEIGHT_W-1:0] w_data,
    input  logic                       timestep_tick,
    output logic [CURRENT_W-1:0]       input_current,
    output logic                       current_valid,
    output logic [COUNT_W-1:0]         spike_count,
    output logic                       overrun
);

    state_t                     state;
    state_t                     next_state;
    logic                       accept;
    logic signed [WEIGHT_W-1:0] stage;
    logic signed [ACC_W-1:0]    acc;
    logic signed [63:0]         sum;
    logic [CURRENT_W-1:0]       clamped;
    logic [COUNT_W-1:0]         win_cnt;

    synapse_weight_rf #(.N_SYN(N_SYN)) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .waddr (w_addr),
        .wdata (w_data),
        .re    (accept),
        .raddr (spike_idx),
        .rdata (stage)
    );

    always_ff @(posedge clk) begin
        state <= reset ? ACCUM : next_state;
    end

    always_comb begin
        next_state = state == ACCUM ? (timestep_tick ? DRAIN : ACCUM) :
                     state == DRAIN ? EMIT : ACCUM;
    end

    always_comb begin
        spike_ready = state == ACCUM;
    end

    assign accept = spike_valid & spike_ready;

    // Stage is zero when no event was accepted, so adding it every cycle is harmless;
    // in DRAIN it carries the event accepted alongside the tick.
    always_comb begin
        sum     = sat_add(64'(acc), 64'(stage), ACC_W);
        clamped = sum < 64'sd0 ? '0 : sum > 64'sd65535 ? '1 : sum[CURRENT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc           <= '0;
            win_cnt       <= '0;
            input_current <= '0;
            current_valid <= 1'b0;
            spike_count   <= '0;
            overrun       <= 1'b0;
        end else begin
            acc           <= state == DRAIN ? '0 : sum[ACC_W-1:0];
            win_cnt       <= state == DRAIN ? '0 :
                             (accept && win_cnt != '1) ? win_cnt + 1'b1 : win_cnt;
            current_valid <= state == DRAIN;
            overrun       <= overrun | (timestep_tick && state != ACCUM);
            if (state == DRAIN) begin
                input_current <= clamped;
                spike_count   <= win_cnt;
            end
        end
    end

endmodule

// File: tb/tb_synaptic_accumulator.sv
`timescale 1ns/1ps
// tb_synaptic_accumulator: vector table, corner sequences and randomized windows vs a sum model
module tb_synaptic_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spike_valid = 1'b0;
    logic [3:0]  spike_idx = '0;
    logic        spike_ready;
    logic        w_we = 1'b0;
    logic [3:0]  w_addr = '0;
    logic [15:0] w_data = '0;
    logic        timestep_tick = 1'b0;
    logic [15:0] input_current;
    logic        current_valid;
    logic [7:0]  spike_count;
    logic        overrun;

    int passed = 0;
    int checks = 0;
    longint mw [16];

    synaptic_accumulator #(.N_SYN(16), .ACC_W(24)) dut (
        .clk           (clk),
        .reset         (reset),
        .spike_valid   (spike_valid),
        .spike_idx     (spike_idx),
        .spike_ready   (spike_ready),
        .w_we          (w_we),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .timestep_tick (timestep_tick),
        .input_current (input_current),
        .current_valid (current_valid),
        .spike_count   (spike_count),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic wr(input int a, input longint d);
        w_we = 1'b1;
        w_addr = 4'(a);
        w_data = 16'(d);
        cyc();
        w_we = 1'b0;
        mw[a] = d;
    endtask

    task automatic ev(input int i);
        spike_valid = 1'b1;
        spike_idx = 4'(i);
        cyc();
        spike_valid = 1'b0;
    endtask

    task automatic close_window(input string nm, input longint ec, input longint en);
        timestep_tick = 1'b1;
        cyc();
        timestep_tick = 1'b0;
        chk({nm, "_ready_drain"}, spike_ready, 0);
        chk({nm, "_valid_drain"}, current_valid, 0);
        cyc();
        chk({nm, "_valid"}, current_valid, 1);
        chk({nm, "_current"}, input_current, ec);
        chk({nm, "_count"}, spike_count, en);
        cyc();
        chk({nm, "_valid_off"}, current_valid, 0);
        chk({nm, "_ready_back"}, spike_ready, 1);
        chk({nm, "_current_hold"}, input_current, ec);
    endtask

    function automatic longint msat(input longint x);
        return x > 8388607 ? 8388607 : x < -8388608 ? -8388608 : x;
    endfunction

    function automatic longint mclamp(input longint x);
        return x < 0 ? 0 : x > 65535 ? 65535 : x;
    endfunction

    typedef struct {
        string  name;
        int     n;
        int     idx [4];
        longint cur;
        longint cnt;
    } vec_t;

    vec_t vt [5];

    initial begin
        int pulses;
        vt[0] = '{"basic",   3, '{0, 0, 1, 0}, 170, 3};
        vt[1] = '{"neg",     1, '{3, 0, 0, 0}, 0, 1};
        vt[2] = '{"empty",   0, '{0, 0, 0, 0}, 0, 0};
        vt[3] = '{"mix",     4, '{4, 4, 2, 1}, 2470, 4};
        vt[4] = '{"pair",    2, '{2, 3, 0, 0}, 300, 2};

        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_ready", spike_ready, 1);
        chk("rst_valid", current_valid, 0);
        chk("rst_current", input_current, 0);
        chk("rst_count", spike_count, 0);
        chk("rst_overrun", overrun, 0);

        wr(0, 100);
        wr(1, -30);
        wr(2, 500);
        wr(3, -200);
        wr(4, 1000);
        wr(5, 1);
        wr(6, 32767);

        for (int v = 0; v < 5; v++) begin
            for (int e = 0; e < vt[v].n; e++) ev(vt[v].idx[e]);
            close_window(vt[v].name, vt[v].cur, vt[v].cnt);
        end

        // event accepted together with the tick belongs to the closing window
        spike_valid = 1'b1;
        spike_idx = 4'd2;
        close_window("tick_event", 500, 1);
        spike_valid = 1'b0;

        // saturation: 300 events of 32767
        spike_valid = 1'b1;
        spike_idx = 4'd6;
        for (int k = 0; k < 300; k++) cyc();
        spike_valid = 1'b0;
        close_window("saturate", 65535, 255);

        // same-cycle write and read of weight 5 returns the old weight
        w_we = 1'b1;
        w_addr = 4'd5;
        w_data = 16'd7;
        spike_valid = 1'b1;
        spike_idx = 4'd5;
        cyc();
        w_we = 1'b0;
        spike_valid = 1'b0;
        mw[5] = 7;
        close_window("wr_collide_old", 1, 1);
        ev(5);
        close_window("wr_collide_new", 7, 1);

        // tick during DRAIN: overrun set, only one emit
        chk("overrun_clear", overrun, 0);
        ev(0);
        timestep_tick = 1'b1;
        cyc();
        chk("ovr_in_drain", spike_ready, 0);
        cyc();
        timestep_tick = 1'b0;
        chk("ovr_valid", current_valid, 1);
        chk("ovr_current", input_current, 100);
        chk("ovr_flag", overrun, 1);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            pulses += int'(current_valid);
        end
        chk("ovr_no_extra_emit", pulses, 0);
        chk("ovr_sticky", overrun, 1);

        // reset mid-window discards partial sum and in-flight events
        ev(4);
        ev(4);
        spike_valid = 1'b1;
        spike_idx = 4'd4;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        spike_valid = 1'b0;
        chk("rst2_ready", spike_ready, 1);
        chk("rst2_overrun", overrun, 0);
        chk("rst2_current", input_current, 0);
        chk("rst2_valid", current_valid, 0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            pulses += int'(current_valid);
        end
        chk("rst2_no_emit", pulses, 0);
        ev(0);
        close_window("rst2_weights_kept", 100, 1);

        // randomized windows against a plain sum model
        for (int w = 0; w < 20; w++) begin
            longint acc;
            longint cnt;
            int n;
            acc = 0;
            cnt = 0;
            n = $urandom_range(0, 12);
            for (int c = 0; c < n; c++) begin
                logic        v;
                logic        we;
                logic [3:0]  i;
                logic [3:0]  a;
                logic [15:0] d;
                v = 1'($urandom_range(0, 1));
                we = $urandom_range(0, 2) == 0;
                i = 4'($urandom);
                a = 4'($urandom);
                d = $urandom_range(0, 3) == 0 ? 16'h7fff : 16'($urandom);
                spike_valid = v;
                spike_idx = i;
                w_we = we;
                w_addr = a;
                w_data = d;
                if (v) begin
                    acc = msat(acc + mw[i]);
                    cnt++;
                end
                if (we) mw[a] = longint'($signed(d));
                cyc();
                spike_valid = 1'b0;
                w_we = 1'b0;
            end
            close_window($sformatf("rand%0d", w), mclamp(acc), cnt > 255 ? 255 : cnt);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
